// File: rtl/spmv_pkg.sv
// spmv_pkg: shared definitions for the CSR sparse matrix-vector engine.
//   - load-stream kind encodings (in_kind)
//   - compute state machine encoding
//   - width helpers used to size address and count fields
package spmv_pkg;

  localparam logic [1:0] KIND_PTR = 2'd0;
  localparam logic [1:0] KIND_COL = 2'd1;
  localparam logic [1:0] KIND_VAL = 2'd2;
  localparam logic [1:0] KIND_X   = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PTR  = 3'd1,
    PTRW = 3'd2,
    RD   = 3'd3,
    XRD  = 3'd4,
    ACC  = 3'd5,
    EMIT = 3'd6,
    DONE = 3'd7
  } state_t;

  // Bits needed to address 'depth' entries (never less than 1).
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Bits needed to hold a count in the range 0..cap inclusive.
  function automatic int count_w(input int cap);
    return addr_w(cap + 1);
  endfunction

endpackage

// File: rtl/csr_sdp_ram.sv
// csr_sdp_ram: parametrised RAM with one write port and RD_PORTS synchronous
// read ports (1-cycle latency). RD_PORTS=2 gives the dual-read variant used
// for the row-pointer store. Contents are not reset.
// Ports:
//   clk          - clock
//   we/waddr     - write enable and address
//   wdata        - write data
//   raddr[p]     - read address of port p
//   rdata[p]     - registered read data of port p
module csr_sdp_ram
  import spmv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int RD_PORTS = 1,
  parameter int AW       = addr_w(DEPTH)
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic [AW-1:0]                      waddr,
  input  logic [WIDTH-1:0]                   wdata,
  input  logic [RD_PORTS-1:0][AW-1:0]        raddr,
  output logic [RD_PORTS-1:0][WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read ports, all sampled on the same edge.
  always_ff @(posedge clk) begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rdata[p] <= mem[raddr[p]];
    end
  end

endmodule

// File: rtl/csr_spmv_engine.sv
// csr_spmv_engine: loads a CSR matrix (row pointers, column indices, values)
// and a dense vector x over one streaming port, then computes y = A*x and
// emits one result per row with valid/ready backpressure.
// Ports:
//   clk, reset                - clock, synchronous active-low reset
//   in_valid/in_ready         - load beat handshake (IDLE only)
//   in_kind/in_data           - beat target store and payload
//   cfg_rows, start           - row count and compute request
//   busy, done                - compute in progress, end-of-matrix pulse
//   out_valid/out_ready       - result handshake
//   out_row/out_data/out_zero - row index, dot product, empty-row flag
//   err                       - sticky error, cleared by an accepted start
// Assumes DATA_W is at least as wide as every store's count field.
module csr_spmv_engine
  import spmv_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 64,
  parameter int MAX_ROWS = 1024,
  parameter int MAX_NNZ  = 16384,
  parameter int MAX_COLS = 1024,
  parameter int SIGNED   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_kind,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [count_w(MAX_ROWS)-1:0]  cfg_rows,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [addr_w(MAX_ROWS)-1:0]   out_row,
  output logic [ACC_W-1:0]              out_data,
  output logic                          out_zero,
  output logic                          err
);

  localparam int RW  = count_w(MAX_ROWS);     // row counter / row-pointer address
  localparam int OW  = addr_w(MAX_ROWS);
  localparam int PCW = count_w(MAX_ROWS + 1); // row-pointer store count
  localparam int NAW = addr_w(MAX_NNZ);
  localparam int KW  = count_w(MAX_NNZ);      // nonzero index, may equal MAX_NNZ
  localparam int XAW = addr_w(MAX_COLS);
  localparam int XCW = count_w(MAX_COLS);
  localparam int PW  = 2 * DATA_W;

  state_t              state_r;
  logic [PCW-1:0]      ptr_cnt_r;
  logic [KW-1:0]       col_cnt_r;
  logic [KW-1:0]       val_cnt_r;
  logic [XCW-1:0]      x_cnt_r;
  logic [RW-1:0]       rows_r;
  logic [RW-1:0]       r_r;
  logic [KW-1:0]       k_r;
  logic [KW-1:0]       hi_r;
  logic [ACC_W-1:0]    acc_r;
  logic [DATA_W-1:0]   val_r;
  logic                col_ok_r;
  logic                busy_r;
  logic                done_r;
  logic                out_valid_r;
  logic                out_zero_r;
  logic [OW-1:0]       out_row_r;
  logic [ACC_W-1:0]    out_data_r;
  logic                err_r;

  logic                in_ready_s;
  logic                accept_s;
  logic                ptr_full_s;
  logic                col_full_s;
  logic                val_full_s;
  logic                x_full_s;
  logic                ptr_we_s;
  logic                col_we_s;
  logic                val_we_s;
  logic                x_we_s;
  logic                start_ok_s;
  logic                ptr_bad_s;
  logic                col_ok_s;
  logic [1:0][RW-1:0]  ptr_raddr_s;
  logic [1:0][DATA_W-1:0] ptr_rdata_s;
  logic [DATA_W-1:0]   col_rdata_s;
  logic [DATA_W-1:0]   val_rdata_s;
  logic [DATA_W-1:0]   x_rdata_s;
  logic [DATA_W-1:0]   lo_s;
  logic [DATA_W-1:0]   hi_s;
  logic [DATA_W-1:0]   x_eff_s;
  logic [PW-1:0]       prod_s;
  logic [ACC_W-1:0]    term_s;
  logic [ACC_W-1:0]    acc_nxt_s;
  logic [KW-1:0]       k_nxt_s;
  logic [RW-1:0]       r_nxt_s;

  // Start wins over a same-cycle load beat.
  assign in_ready_s = (state_r == IDLE) && !start;
  assign accept_s   = in_valid && in_ready_s;

  assign ptr_full_s = (ptr_cnt_r == PCW'(MAX_ROWS + 1));
  assign col_full_s = (col_cnt_r == KW'(MAX_NNZ));
  assign val_full_s = (val_cnt_r == KW'(MAX_NNZ));
  assign x_full_s   = (x_cnt_r   == XCW'(MAX_COLS));

  assign ptr_we_s = accept_s && (in_kind == KIND_PTR) && !ptr_full_s;
  assign col_we_s = accept_s && (in_kind == KIND_COL) && !col_full_s;
  assign val_we_s = accept_s && (in_kind == KIND_VAL) && !val_full_s;
  assign x_we_s   = accept_s && (in_kind == KIND_X)   && !x_full_s;

  // A valid matrix has exactly rows+1 row pointers.
  assign start_ok_s = (cfg_rows != {RW{1'b0}}) &&
                      (ptr_cnt_r == (PCW'(cfg_rows) + PCW'(1'b1)));

  assign r_nxt_s = r_r + RW'(1'b1);
  assign k_nxt_s = k_r + KW'(1'b1);

  assign ptr_raddr_s[0] = r_r;
  assign ptr_raddr_s[1] = r_nxt_s;
  assign lo_s = ptr_rdata_s[0];
  assign hi_s = ptr_rdata_s[1];

  // A pointer equal to MAX_NNZ is a legal exclusive end bound; larger is not.
  assign ptr_bad_s = (lo_s > DATA_W'(MAX_NNZ)) || (hi_s > DATA_W'(MAX_NNZ)) ||
                     (hi_s < lo_s);
  assign col_ok_s  = (col_rdata_s < DATA_W'(x_cnt_r));

  csr_sdp_ram #(.WIDTH(DATA_W), .DEPTH(MAX_ROWS + 1), .RD_PORTS(2)) u_ptr_ram (
    .clk   (clk),
    .we    (ptr_we_s),
    .waddr (ptr_cnt_r[RW-1:0]),
    .wdata (in_data),
    .raddr (ptr_raddr_s),
    .rdata (ptr_rdata_s)
  );

  csr_sdp_ram #(.WIDTH(DATA_W), .DEPTH(MAX_NNZ), .RD_PORTS(1)) u_col_ram (
    .clk   (clk),
    .we    (col_we_s),
    .waddr (col_cnt_r[NAW-1:0]),
    .wdata (in_data),
    .raddr (k_r[NAW-1:0]),
    .rdata (col_rdata_s)
  );

  csr_sdp_ram #(.WIDTH(DATA_W), .DEPTH(MAX_NNZ), .RD_PORTS(1)) u_val_ram (
    .clk   (clk),
    .we    (val_we_s),
    .waddr (val_cnt_r[NAW-1:0]),
    .wdata (in_data),
    .raddr (k_r[NAW-1:0]),
    .rdata (val_rdata_s)
  );

  // Out-of-range columns still drive an address; the read data is masked.
  csr_sdp_ram #(.WIDTH(DATA_W), .DEPTH(MAX_COLS), .RD_PORTS(1)) u_x_ram (
    .clk   (clk),
    .we    (x_we_s),
    .waddr (x_cnt_r[XAW-1:0]),
    .wdata (in_data),
    .raddr (col_rdata_s[XAW-1:0]),
    .rdata (x_rdata_s)
  );

  // Full-width product, extended to the accumulator width per signedness.
  always_comb begin
    x_eff_s = col_ok_r ? x_rdata_s : {DATA_W{1'b0}};
    if (SIGNED != 0) begin
      prod_s = PW'($signed(val_r)) * PW'($signed(x_eff_s));
      term_s = ACC_W'($signed(prod_s));
    end else begin
      prod_s = PW'(val_r) * PW'(x_eff_s);
      term_s = ACC_W'(prod_s);
    end
    acc_nxt_s = acc_r + term_s;
  end

  // Load pointers, compute state machine and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      ptr_cnt_r   <= {PCW{1'b0}};
      col_cnt_r   <= {KW{1'b0}};
      val_cnt_r   <= {KW{1'b0}};
      x_cnt_r     <= {XCW{1'b0}};
      rows_r      <= {RW{1'b0}};
      r_r         <= {RW{1'b0}};
      k_r         <= {KW{1'b0}};
      hi_r        <= {KW{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      val_r       <= {DATA_W{1'b0}};
      col_ok_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_zero_r  <= 1'b0;
      out_row_r   <= {OW{1'b0}};
      out_data_r  <= {ACC_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (start_ok_s) begin
              err_r   <= 1'b0;
              rows_r  <= cfg_rows;
              r_r     <= {RW{1'b0}};
              busy_r  <= 1'b1;
              state_r <= PTR;
            end else begin
              err_r <= 1'b1;
            end
          end else if (accept_s) begin
            // Writes past capacity are dropped and flagged.
            case (in_kind)
              KIND_PTR: if (ptr_full_s) err_r <= 1'b1; else ptr_cnt_r <= ptr_cnt_r + PCW'(1'b1);
              KIND_COL: if (col_full_s) err_r <= 1'b1; else col_cnt_r <= col_cnt_r + KW'(1'b1);
              KIND_VAL: if (val_full_s) err_r <= 1'b1; else val_cnt_r <= val_cnt_r + KW'(1'b1);
              KIND_X:   if (x_full_s)   err_r <= 1'b1; else x_cnt_r   <= x_cnt_r + XCW'(1'b1);
              default:  err_r <= err_r;
            endcase
          end
        end
        PTR: begin
          out_row_r <= r_r[OW-1:0];
          state_r   <= PTRW;
        end
        PTRW: begin
          if (ptr_bad_s || (hi_s == lo_s)) begin
            if (ptr_bad_s) begin
              err_r <= 1'b1;
            end
            out_zero_r  <= 1'b1;
            out_data_r  <= {ACC_W{1'b0}};
            out_valid_r <= 1'b1;
            state_r     <= EMIT;
          end else begin
            k_r     <= lo_s[KW-1:0];
            hi_r    <= hi_s[KW-1:0];
            acc_r   <= {ACC_W{1'b0}};
            state_r <= RD;
          end
        end
        RD: begin
          state_r <= XRD;
        end
        XRD: begin
          val_r    <= val_rdata_s;
          col_ok_r <= col_ok_s;
          if (!col_ok_s) begin
            err_r <= 1'b1;
          end
          state_r <= ACC;
        end
        ACC: begin
          acc_r <= acc_nxt_s;
          k_r   <= k_nxt_s;
          if (k_nxt_s == hi_r) begin
            out_data_r  <= acc_nxt_s;
            out_zero_r  <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= EMIT;
          end else begin
            state_r <= RD;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            r_r         <= r_nxt_s;
            if (r_nxt_s == rows_r) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= PTR;
            end
          end
        end
        DONE: begin
          done_r    <= 1'b0;
          ptr_cnt_r <= {PCW{1'b0}};
          col_cnt_r <= {KW{1'b0}};
          val_cnt_r <= {KW{1'b0}};
          x_cnt_r   <= {XCW{1'b0}};
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign busy      = busy_r;
  assign done      = done_r;
  assign out_valid = out_valid_r;
  assign out_row   = out_row_r;
  assign out_data  = out_data_r;
  assign out_zero  = out_zero_r;
  assign err       = err_r;

endmodule

// File: tb/tb_csr_spmv_engine.sv
// Self-checking bench for csr_spmv_engine: table-driven single-row vectors
// plus hand-written multi-row, backpressure, error and reset sequences.
// Expected results are queued when a run starts and popped at each handshake.
module tb_csr_spmv_engine;

  localparam int MR = 4;
  localparam int MN = 8;
  localparam int MC = 16;

  localparam logic [1:0] K_PTR = 2'd0;
  localparam logic [1:0] K_COL = 2'd1;
  localparam logic [1:0] K_VAL = 2'd2;
  localparam logic [1:0] K_X   = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [31:0] in_data;
  logic [2:0]  cfg_rows;
  logic        start;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_row;
  logic [63:0] out_data;
  logic        out_zero;
  logic        err;

  csr_spmv_engine #(
    .DATA_W(32), .ACC_W(64), .MAX_ROWS(MR), .MAX_NNZ(MN), .MAX_COLS(MC), .SIGNED(1)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_data(in_data), .cfg_rows(cfg_rows), .start(start),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data), .out_zero(out_zero), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  row;
    logic [63:0] data;
    logic        zero;
  } exp_t;

  typedef struct {
    int              nnz;
    logic [1:0][31:0] col;   // {col1, col0}
    logic [1:0][31:0] val;   // {val1, val0}
    logic [31:0]     x0;
    logic [31:0]     x1;
    logic [63:0]     exp;
    logic            zero;
    logic            err;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [1:0] k, input logic [31:0] d);
    in_valid = 1'b1;
    in_kind  = k;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, out_valid, 1'b0);
    check({tag, " busy"},      busy,      1'b0);
    check({tag, " done"},      done,      1'b0);
    check({tag, " err"},       err,       1'b0);
    check({tag, " out_zero"},  out_zero,  1'b0);
    check({tag, " out_data"},  out_data,  64'd0);
    check({tag, " out_row"},   out_row,   2'd0);
    check({tag, " in_ready"},  in_ready,  1'b1);
  endtask

  task automatic load_identity();
    beat(K_PTR, 32'd0); beat(K_PTR, 32'd1); beat(K_PTR, 32'd2);
    beat(K_COL, 32'd0); beat(K_COL, 32'd1);
    beat(K_VAL, 32'd1); beat(K_VAL, 32'd1);
    beat(K_X, 32'd5);   beat(K_X, 32'd7);
  endtask

  // Pulse start for one cycle; optionally offer a load beat alongside it.
  task automatic start_run(input logic [2:0] rows, input bit with_beat);
    cfg_rows = rows;
    start    = 1'b1;
    if (with_beat) begin
      in_valid = 1'b1; in_kind = K_X; in_data = 32'hdead;
    end
    #1;
    if (with_beat) check("in_ready with start", in_ready, 1'b0);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  // Runs from the negedge after the start edge (index 0 = PTR) until done.
  task automatic drain(input string tag, input int budget, input int exp_lat, input int exp_gap);
    int   idx = 0;
    int   first = -1;
    int   last_hs = -1;
    int   gap = -1;
    bit   seen_done = 1'b0;
    exp_t e;
    while (!seen_done && idx < budget) begin
      if (out_valid && first < 0) first = idx;
      if (done) begin
        seen_done = 1'b1;
        check({tag, " busy at done"}, busy, 1'b0);
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL %s unexpected output: row %0d data 0x%0h", tag, out_row, out_data);
        end else begin
          e = sb.pop_front();
          check($sformatf("%s row%0d index", tag, e.row), out_row, e.row);
          check($sformatf("%s row%0d data", tag, e.row), out_data, e.data);
          check($sformatf("%s row%0d zero", tag, e.row), out_zero, e.zero);
        end
        if (last_hs >= 0) gap = idx - last_hs;
        last_hs = idx;
      end
      if (!seen_done) begin
        @(negedge clk);
        idx++;
      end
    end
    check({tag, " done seen"}, seen_done, 1'b1);
    check({tag, " results left"}, sb.size(), 64'd0);
    if (exp_lat >= 0) check({tag, " first latency"}, first, exp_lat);
    if (exp_gap >= 0) check({tag, " row gap"}, gap, exp_gap);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_kind = 2'd0; in_data = 32'd0; cfg_rows = 3'd0;
    tbl[0] = '{1, {32'd0, 32'd0}, {32'd0, 32'd3}, 32'd10, 32'd20, 64'd30, 1'b0, 1'b0};
    tbl[1] = '{2, {32'd0, 32'd1}, {32'd5, 32'hFFFFFFFE}, 32'd7, 32'hFFFFFFFD, 64'd41, 1'b0, 1'b0};
    tbl[2] = '{2, {32'd0, 32'd0}, {32'h7FFFFFFF, 32'h7FFFFFFF}, 32'h7FFFFFFF, 32'd0,
               64'h7FFFFFFE00000002, 1'b0, 1'b0};
    tbl[3] = '{1, {32'd0, 32'd0}, {32'd0, 32'h80000000}, 32'h80000000, 32'd0,
               64'h4000000000000000, 1'b0, 1'b0};
    tbl[4] = '{2, {32'd0, 32'd0}, {32'h80000000, 32'h80000000}, 32'h80000000, 32'd0,
               64'h8000000000000000, 1'b0, 1'b0};
    tbl[5] = '{0, {32'd0, 32'd0}, {32'd0, 32'd0}, 32'd3, 32'd4, 64'd0, 1'b1, 1'b0};
    tbl[6] = '{2, {32'd9, 32'd1}, {32'd100, 32'd4}, 32'd1, 32'hFFFFFFFA,
               64'hFFFFFFFFFFFFFFE8, 1'b0, 1'b1};
    tbl[7] = '{1, {32'd0, 32'd1}, {32'd0, 32'hFFFFFFFF}, 32'd0, 32'hFFFFFFFF, 64'd1, 1'b0, 1'b0};

    do_reset();
    check_reset_outputs("reset");

    // Identity 2x2 with x=(5,7); a load beat is offered with start.
    load_identity();
    sb.push_back('{2'd0, 64'd5, 1'b0});
    sb.push_back('{2'd1, 64'd7, 1'b0});
    start_run(3'd2, 1'b1);
    drain("identity", 200, 5, 6);
    check("identity err", err, 1'b0);

    // Empty row then a signed row: -2*4 + 3*(-1) = -11.
    do_reset();
    beat(K_PTR, 32'd0); beat(K_PTR, 32'd0); beat(K_PTR, 32'd2);
    beat(K_COL, 32'd0); beat(K_COL, 32'd1);
    beat(K_VAL, 32'hFFFFFFFE); beat(K_VAL, 32'd3);
    beat(K_X, 32'd4); beat(K_X, 32'hFFFFFFFF);
    sb.push_back('{2'd0, 64'd0, 1'b1});
    sb.push_back('{2'd1, 64'hFFFFFFFFFFFFFFF5, 1'b0});
    start_run(3'd2, 1'b0);
    drain("signed", 200, 2, 9);

    // Table of single-row vectors.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      beat(K_PTR, 32'd0);
      beat(K_PTR, 32'(tbl[i].nnz));
      for (int j = 0; j < tbl[i].nnz; j++) beat(K_COL, tbl[i].col[j]);
      for (int j = 0; j < tbl[i].nnz; j++) beat(K_VAL, tbl[i].val[j]);
      beat(K_X, tbl[i].x0);
      beat(K_X, tbl[i].x1);
      sb.push_back('{2'd0, tbl[i].exp, tbl[i].zero});
      start_run(3'd1, 1'b0);
      drain($sformatf("vec%0d", i), 100, 2 + 3 * tbl[i].nnz, -1);
      check($sformatf("vec%0d err", i), err, tbl[i].err);
    end

    // Backpressure: row 0 held for 10 cycles.
    do_reset();
    load_identity();
    sb.push_back('{2'd0, 64'd5, 1'b0});
    sb.push_back('{2'd1, 64'd7, 1'b0});
    out_ready = 1'b0;
    start_run(3'd2, 1'b0);
    begin
      int w = 0;
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
    end
    check("bp valid rises", out_valid, 1'b1);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp hold%0d valid", c), out_valid, 1'b1);
      check($sformatf("bp hold%0d row", c), out_row, 2'd0);
      check($sformatf("bp hold%0d data", c), out_data, 64'd5);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain("bp", 100, -1, -1);

    // Start with a row-pointer count that does not match cfg_rows+1.
    do_reset();
    beat(K_PTR, 32'd0); beat(K_PTR, 32'd1); beat(K_PTR, 32'd2);
    start_run(3'd3, 1'b0);
    check("bad start err", err, 1'b1);
    check("bad start busy", busy, 1'b0);
    begin
      int seen = 0;
      repeat (10) begin
        if (done || busy) seen++;
        @(negedge clk);
      end
      check("bad start quiet", seen, 64'd0);
    end

    // Column store overflow, then a clean start clears err.
    do_reset();
    for (int i = 0; i < 9; i++) beat(K_COL, 32'(i));
    check("overflow err", err, 1'b1);
    beat(K_PTR, 32'd0); beat(K_PTR, 32'd1);
    beat(K_VAL, 32'd6); beat(K_X, 32'd7);
    sb.push_back('{2'd0, 64'd42, 1'b0});
    start_run(3'd1, 1'b0);
    check("start clears err", err, 1'b0);
    drain("overflow", 100, 5, -1);
    check("overflow run err", err, 1'b0);

    // Reset asserted while row 0 is in ACC.
    do_reset();
    load_identity();
    start_run(3'd2, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid-acc");
    reset = 1'b1;
    start_run(3'd1, 1'b0);
    check("after abort ptrs cleared err", err, 1'b1);
    check("after abort busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
